jtag_seq_driver: RTL

- Upstream TMS/TDI sequencer for the TAP controller; runs in the same clock domain as the TAP and drives its TMS input.
- Accepts one command at a time over a valid/ready handshake: TAP reset, idle run, IR shift or DR shift.
- For each command it generates the exact TMS/TDI cycle sequence and samples TDO.
- Keeps a mirror of the TAP state, using the TAP's 4-bit state encoding (TestLogicReset=0 … UpdateIR=15), for debug and checking.

---
 rtl/jtag_seq_driver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/jtag_seq_driver.sv
// Upstream TMS/TDI sequencer for a TAP controller in the same clock domain.
// Runs one command at a time (reset, idle run, IR/DR shift) and mirrors the TAP state.
module jtag_seq_driver #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic [3:0]         tap_st
);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  localparam logic [1:0] OpReset = 2'd0;
  localparam logic [1:0] OpIdle  = 2'd1;
  localparam logic [1:0] OpIr    = 2'd2;

  localparam logic [3:0] TapTlr     = 4'd0;
  localparam logic [3:0] TapRti     = 4'd1;
  localparam logic [3:0] TapSelDr   = 4'd2;
  localparam logic [3:0] TapCapDr   = 4'd3;
  localparam logic [3:0] TapShDr    = 4'd4;
  localparam logic [3:0] TapEx1Dr   = 4'd5;
  localparam logic [3:0] TapPauseDr = 4'd6;
  localparam logic [3:0] TapEx2Dr   = 4'd7;
  localparam logic [3:0] TapUpdDr   = 4'd8;
  localparam logic [3:0] TapSelIr   = 4'd9;
  localparam logic [3:0] TapCapIr   = 4'd10;
  localparam logic [3:0] TapShIr    = 4'd11;
  localparam logic [3:0] TapEx1Ir   = 4'd12;
  localparam logic [3:0] TapPauseIr = 4'd13;
  localparam logic [3:0] TapEx2Ir   = 4'd14;
  localparam logic [3:0] TapUpdIr   = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_PRE, S_RUN, S_HEAD, S_SHIFT, S_TAIL, S_DONE
  } state_e;

  function automatic logic [3:0] tap_next(input logic [3:0] st, input logic tms);
    logic [3:0] nxt;
    case (st)
      TapTlr:     nxt = tms ? TapTlr     : TapRti;
      TapRti:     nxt = tms ? TapSelDr   : TapRti;
      TapSelDr:   nxt = tms ? TapSelIr   : TapCapDr;
      TapCapDr:   nxt = tms ? TapEx1Dr   : TapShDr;
      TapShDr:    nxt = tms ? TapEx1Dr   : TapShDr;
      TapEx1Dr:   nxt = tms ? TapUpdDr   : TapPauseDr;
      TapPauseDr: nxt = tms ? TapEx2Dr   : TapPauseDr;
      TapEx2Dr:   nxt = tms ? TapUpdDr   : TapShDr;
      TapUpdDr:   nxt = tms ? TapSelDr   : TapRti;
      TapSelIr:   nxt = tms ? TapTlr     : TapCapIr;
      TapCapIr:   nxt = tms ? TapEx1Ir   : TapShIr;
      TapShIr:    nxt = tms ? TapEx1Ir   : TapShIr;
      TapEx1Ir:   nxt = tms ? TapUpdIr   : TapPauseIr;
      TapPauseIr: nxt = tms ? TapEx2Ir   : TapPauseIr;
      TapEx2Ir:   nxt = tms ? TapUpdIr   : TapShIr;
      TapUpdIr:   nxt = tms ? TapSelDr   : TapRti;
      default:    nxt = TapTlr;
    endcase
    return nxt;
  endfunction

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d, len_in, head_last;
  logic [1:0]         op_q, op_d;
  logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic               tms_q, tms_d, tdi_q, tdi_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic [3:0]         tap_q, tap_d;

  always_comb begin
    if (cmd_len == '0)                      len_in = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_LEN))     len_in = LEN_W'(MAX_LEN);
    else                                    len_in = cmd_len;
  end

  // IR head is 1,1,0,0; DR head is 1,0,0.
  assign head_last = (op_q == OpIr) ? LEN_W'(3) : LEN_W'(2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + LEN_W'(1);
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    tap_d   = tap_next(tap_q, tms_q);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid && ready_q) begin
          op_d   = cmd_op;
          len_d  = len_in;
          data_d = cmd_data;
          cap_d  = '0;
          if (cmd_op == OpReset)     state_d = S_RESET;
          else if (tap_q == TapTlr)  state_d = S_PRE;
          else if (cmd_op == OpIdle) state_d = S_RUN;
          else                       state_d = S_HEAD;
        end
      end
      S_RESET: if (cnt_q == LEN_W'(5)) state_d = S_DONE;
      S_PRE: begin
        cnt_d   = '0;
        state_d = (op_q == OpIdle) ? S_RUN : S_HEAD;
      end
      S_RUN: if (cnt_q == len_q - LEN_W'(1)) state_d = S_DONE;
      S_HEAD: begin
        if (cnt_q == head_last) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        cap_d[cnt_q[IDX_W-1:0]] = TDO;
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = S_TAIL;
          cnt_d   = '0;
        end
      end
      S_TAIL: if (cnt_q == LEN_W'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // TMS/TDI are registered, so they are derived from the state being entered.
    tms_d = (tap_d == TapTlr);
    tdi_d = 1'b0;
    unique case (state_d)
      S_RESET: tms_d = (cnt_d != LEN_W'(5));
      S_PRE, S_RUN: tms_d = 1'b0;
      S_HEAD: tms_d = (op_d == OpIr) ? (cnt_d < LEN_W'(2)) : (cnt_d == '0);
      S_SHIFT: begin
        tms_d = (cnt_d == len_d - LEN_W'(1));
        tdi_d = data_d[cnt_d[IDX_W-1:0]];
      end
      S_TAIL: tms_d = (cnt_d == '0);
      default: ;
    endcase

    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rsp_data_d  = (state_d == S_DONE) ? cap_d : rsp_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tap_q       <= TapTlr;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tap_q       <= tap_d;
    end
  end

  assign cmd_ready = ready_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tap_st    = tap_q;

endmodule
